// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller slice.
//   cond_state_t : farm sensor conditioner states (also exported on condState)
//   SIG_*        : signal light codes, so the farmGreen decode (farmSignal == SIG_GRN)
//                  stays consistent with the controller
package tlc_pkg;

    typedef enum logic [1:0] {
        COND_IDLE    = 2'b00,
        COND_QUALIFY = 2'b01,
        COND_REQUEST = 2'b10,
        COND_SERVE   = 2'b11
    } cond_state_t;

    localparam logic [1:0] SIG_RED = 2'b00;
    localparam logic [1:0] SIG_YEL = 2'b01;
    localparam logic [1:0] SIG_GRN = 2'b10;

endpackage

// File: rtl/sync_debounce.sv
// Synchroniser plus level debouncer for the raw vehicle-loop input.
// Ports:
//   Clk             in  system clock
//   Rst_n           in  asynchronous active-low reset
//   sensorRaw       in  raw loop detector, asynchronous to Clk
//   vehiclePresent  out debounced presence level, registered
// A level change is accepted only after DEBOUNCE_CYCLES consecutive cycles of
// the synchronised input disagreeing with the current level.
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int CNT_W           = 31
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic sensorRaw,
    output logic vehiclePresent
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   syn;
    logic [CNT_W-1:0]       dbCnt;

    assign syn = syncReg[SYNC_STAGES-1];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            syncReg        <= '0;
            dbCnt          <= '0;
            vehiclePresent <= 1'b0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], sensorRaw};
            if (syn != vehiclePresent) begin
                if (dbCnt == DB_LAST) begin
                    vehiclePresent <= syn;
                    dbCnt          <= '0;
                end else if (dbCnt != '1) begin
                    dbCnt <= dbCnt + CNT_W'(1);
                end
            end else begin
                // Any agreeing sample restarts the count, so short glitches vanish.
                dbCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/farm_sensor_cond.sv
// Farm-road sensor conditioner: turns the raw loop input into the farmSensor
// call/extend request for the traffic light controller FSM.
// Ports:
//   Clk             in  system clock
//   Rst_n           in  asynchronous active-low reset
//   sensorRaw       in  raw loop detector, asynchronous to Clk
//   farmGreen       in  high while the farm signal is green
//   farmSensor      out conditioned call/extend request, registered
//   vehiclePresent  out debounced presence level, registered
//   condState       out current conditioner state, for debug
module farm_sensor_cond
    import tlc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int MIN_PRESENCE    = 50000000,
    parameter int CNT_W           = 31
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       sensorRaw,
    input  logic       farmGreen,
    output logic       farmSensor,
    output logic       vehiclePresent,
    output logic [1:0] condState
);

    localparam logic [CNT_W-1:0] PRES_LAST = CNT_W'(MIN_PRESENCE - 1);

    cond_state_t      state, nextState;
    logic [CNT_W-1:0] presCnt;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .sensorRaw      (sensorRaw),
        .vehiclePresent (vehiclePresent)
    );

    always_comb begin
        nextState = state;
        case (state)
            COND_IDLE: begin
                if (vehiclePresent) nextState = COND_QUALIFY;
            end
            COND_QUALIFY: begin
                // Vehicle leaving wins over a coincident timeout.
                if (!vehiclePresent)          nextState = COND_IDLE;
                else if (presCnt == PRES_LAST) nextState = COND_REQUEST;
            end
            COND_REQUEST: begin
                if (farmGreen) nextState = COND_SERVE;
            end
            COND_SERVE: begin
                if (!farmGreen) nextState = vehiclePresent ? COND_QUALIFY : COND_IDLE;
            end
            default: nextState = COND_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= COND_IDLE;
            presCnt    <= '0;
            farmSensor <= 1'b0;
        end else begin
            state <= nextState;
            // Counts only while remaining in QUALIFY; any entry or exit clears it.
            if (state == COND_QUALIFY && nextState == COND_QUALIFY) begin
                if (presCnt != '1) presCnt <= presCnt + CNT_W'(1);
            end else begin
                presCnt <= '0;
            end
            // Decoded from the current state, so farmSensor follows condState
            // one cycle later: the call is latched in REQUEST, live in SERVE.
            farmSensor <= (state == COND_REQUEST) ||
                          (state == COND_SERVE && vehiclePresent);
        end
    end

    assign condState = state;

endmodule

// File: tb/tb_farm_sensor_cond.sv
// Self-checking bench for farm_sensor_cond with short debounce/presence times.
module tb_farm_sensor_cond;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int MINP = 8;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       sensorRaw = 1'b0;
    logic       farmGreen = 1'b0;
    logic       farmSensor;
    logic       vehiclePresent;
    logic [1:0] condState;

    int n_tests = 0;
    int n_fail  = 0;

    farm_sensor_cond #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .MIN_PRESENCE    (MINP),
        .CNT_W           (8)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .sensorRaw      (sensorRaw),
        .farmGreen      (farmGreen),
        .farmSensor     (farmSensor),
        .vehiclePresent (vehiclePresent),
        .condState      (condState)
    );

    always #5 Clk = ~Clk;

    // Reference model. Presence: the level flips once the last DEB synchronised
    // samples (raw delayed by SYNC edges) all disagree with it. Call logic is
    // kept as independent flags plus an age counter inside the qualify window.
    bit [5:0] mRaw;
    bit       mVp, mQual, mCall, mServe, mFs;
    int       mAge;

    always @(posedge Clk or negedge Rst_n) begin : model
        bit [5:0] h;
        bit       nVp, nQual, nCall, nServe;
        int       nAge;
        if (!Rst_n) begin
            mRaw <= '0; mVp <= 1'b0; mQual <= 1'b0; mCall <= 1'b0;
            mServe <= 1'b0; mFs <= 1'b0; mAge <= 0;
        end else begin
            h   = {mRaw[4:0], sensorRaw};
            nVp = mVp;
            if (h[5:2] == {4{~mVp}}) nVp = ~mVp;
            nQual = mQual; nCall = mCall; nServe = mServe; nAge = mAge;
            if (mServe) begin
                if (!farmGreen) begin nServe = 1'b0; nQual = mVp; nAge = 0; end
            end else if (mCall) begin
                if (farmGreen) begin nCall = 1'b0; nServe = 1'b1; end
            end else if (mQual) begin
                if (!mVp) nQual = 1'b0;
                else if (mAge == MINP - 1) begin nQual = 1'b0; nCall = 1'b1; end
                else nAge = mAge + 1;
            end else if (mVp) begin
                nQual = 1'b1; nAge = 0;
            end
            mFs    <= mCall | (mServe & mVp);
            mRaw   <= h;
            mVp    <= nVp;
            mQual  <= nQual;
            mCall  <= nCall;
            mServe <= nServe;
            mAge   <= nAge;
        end
    end

    function automatic logic [1:0] exp_state();
        if (mServe)     return 2'b11;
        else if (mCall) return 2'b10;
        else if (mQual) return 2'b01;
        else            return 2'b00;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; sensorRaw = 1'b0; farmGreen = 1'b0;
        tick(); tick();
        Rst_n = 1'b1;
        tick();
        sensorRaw = 1'b1;
        repeat (10) tick();
        n_tests++;
        if (condState !== 2'b01) begin
            n_fail++; $display("FAIL reset_pre_state: got %b expected 01", condState);
        end
        #3;
        Rst_n = 1'b0;
        #1;
        n_tests++;
        if (condState !== 2'b00) begin
            n_fail++; $display("FAIL reset_state: got %b expected 00", condState);
        end
        n_tests++;
        if (farmSensor !== 1'b0 || vehiclePresent !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got fs=%b vp=%b expected 0 0", farmSensor, vehiclePresent);
        end
        #2;
        sensorRaw = 1'b0;
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_glitch();
        sensorRaw = 1'b1;
        repeat (3) tick();
        sensorRaw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (vehiclePresent !== 1'b0 || condState !== 2'b00) begin
                n_fail++; $display("FAIL glitch: got vp=%b st=%b expected 0 00", vehiclePresent, condState);
            end
        end
    endtask

    task automatic test_call();
        int vpAt, fsAt;
        vpAt = -1; fsAt = -1;
        sensorRaw = 1'b1;
        for (int i = 1; i <= 20 && vpAt < 0; i++) begin
            tick();
            if (vehiclePresent === 1'b1) vpAt = i;
        end
        n_tests++;
        if (vpAt != SYNC + DEB) begin
            n_fail++; $display("FAIL call_debounce_latency: got %0d expected %0d", vpAt, SYNC + DEB);
        end
        tick();
        n_tests++;
        if (condState !== 2'b01) begin
            n_fail++; $display("FAIL call_qualify: got %b expected 01", condState);
        end
        for (int i = 1; i <= 30 && fsAt < 0; i++) begin
            tick();
            if (farmSensor === 1'b1) fsAt = i;
        end
        n_tests++;
        if (fsAt != MINP + 1) begin
            n_fail++; $display("FAIL call_latency: got %0d expected %0d", fsAt, MINP + 1);
        end
        n_tests++;
        if (condState !== 2'b10) begin
            n_fail++; $display("FAIL call_request: got %b expected 10", condState);
        end
    endtask

    task automatic test_latch_serve();
        sensorRaw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (farmSensor !== 1'b1 || condState !== 2'b10) begin
                n_fail++; $display("FAIL latch_hold: got fs=%b st=%b expected 1 10", farmSensor, condState);
            end
        end
        farmGreen = 1'b1;
        tick();
        n_tests++;
        if (condState !== 2'b11) begin
            n_fail++; $display("FAIL serve_enter: got %b expected 11", condState);
        end
        tick();
        n_tests++;
        if (farmSensor !== 1'b0) begin
            n_fail++; $display("FAIL serve_empty: got %b expected 0", farmSensor);
        end
        farmGreen = 1'b0;
        tick();
        n_tests++;
        if (condState !== 2'b00) begin
            n_fail++; $display("FAIL serve_exit_idle: got %b expected 00", condState);
        end
    endtask

    task automatic test_extend();
        bit reached;
        reached = 1'b0;
        sensorRaw = 1'b1;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (condState === 2'b10) reached = 1'b1;
        end
        n_tests++;
        if (!reached) begin
            n_fail++; $display("FAIL extend_request_timeout: got %b expected 10", condState);
        end
        farmGreen = 1'b1;
        tick();
        n_tests++;
        if (condState !== 2'b11) begin
            n_fail++; $display("FAIL extend_serve: got %b expected 11", condState);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (farmSensor !== 1'b1 || condState !== 2'b11) begin
                n_fail++; $display("FAIL extend_hold: got fs=%b st=%b expected 1 11", farmSensor, condState);
            end
        end
        farmGreen = 1'b0;
        tick();
        n_tests++;
        if (condState !== 2'b01) begin
            n_fail++; $display("FAIL extend_requalify: got %b expected 01", condState);
        end
        for (int i = 1; i <= MINP + 1; i++) begin
            tick();
            n_tests++;
            if (condState !== ((i < MINP) ? 2'b01 : 2'b10) ||
                farmSensor !== ((i == MINP + 1) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL extend_restart: cycle %0d got st=%b fs=%b", i, condState, farmSensor);
            end
        end
        sensorRaw = 1'b0;
        farmGreen = 1'b1;
        tick();
        farmGreen = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (condState === 2'b00 && vehiclePresent === 1'b0) reached = 1'b1;
        end
        n_tests++;
        if (!reached) begin
            n_fail++; $display("FAIL extend_cleanup_timeout: got %b expected 00", condState);
        end
    endtask

    // Raw drops `lag` cycles after entering QUALIFY; the debounced drop then
    // lands at presence count lag+6, returning to IDLE at cycle lag+7.
    task automatic test_abort(input int lag, input string name);
        bit reached;
        int idleAt;
        reached = 1'b0; idleAt = -1;
        sensorRaw = 1'b1;
        for (int i = 0; i < 30 && !reached; i++) begin
            tick();
            if (condState === 2'b01) reached = 1'b1;
        end
        n_tests++;
        if (!reached) begin
            n_fail++; $display("FAIL %s_qualify_timeout: got %b expected 01", name, condState);
        end
        for (int i = 1; i <= 20; i++) begin
            if (i == lag + 1) sensorRaw = 1'b0;
            tick();
            if (condState === 2'b00 && idleAt < 0) idleAt = i;
            n_tests++;
            if (farmSensor !== 1'b0 || condState === 2'b10) begin
                n_fail++; $display("FAIL %s_no_call: got fs=%b st=%b expected 0", name, farmSensor, condState);
            end
        end
        n_tests++;
        if (idleAt != lag + 7) begin
            n_fail++; $display("FAIL %s_idle_cycle: got %0d expected %0d", name, idleAt, lag + 7);
        end
    endtask

    task automatic test_unrequested_green();
        farmGreen = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (condState !== 2'b00 || farmSensor !== 1'b0) begin
                n_fail++; $display("FAIL green_idle: got st=%b fs=%b expected 00 0", condState, farmSensor);
            end
        end
        farmGreen = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int holdRaw, holdFg;
        holdRaw = 0; holdFg = 0;
        for (int i = 0; i < 800; i++) begin
            if (holdRaw == 0) begin
                sensorRaw = 1'($urandom_range(0, 1));
                holdRaw   = $urandom_range(1, 14);
            end
            if (holdFg == 0) begin
                farmGreen = ($urandom_range(0, 9) < 3);
                holdFg    = $urandom_range(1, 30);
            end
            holdRaw--; holdFg--;
            tick();
            n_tests++;
            if (vehiclePresent !== mVp || farmSensor !== mFs || condState !== exp_state()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got vp=%b fs=%b st=%b expected vp=%b fs=%b st=%b",
                         i, vehiclePresent, farmSensor, condState, mVp, mFs, exp_state());
            end
        end
        sensorRaw = 1'b0;
        farmGreen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_call();
        test_latch_serve();
        test_extend();
        test_abort(0, "abort");
        test_abort(1, "drop_priority");
        test_unrequested_green();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
